// File: rtl/serial_parity_checker_pkg.sv
// Shared definitions for the serial parity checker: FSM state encoding and
// parity-mode constants, reused by parity generators and benches.
package serial_parity_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Seed value of the running parity accumulator for a given mode, chosen so
    // that a correct frame always leaves the accumulator at zero.
    function automatic logic parity_seed(input int odd_parity);
        return (odd_parity != 0) ? PARITY_ODD : PARITY_EVEN;
    endfunction

endpackage

// File: rtl/serial_parity_checker_edge_tick.sv
// Brings the divided clock into the clk_in domain as plain data and produces a
// single-cycle tick for each of its rising edges.
module edge_tick_sync (
    input  logic clk_in,
    input  logic reset,
    input  logic slow_clk,
    output logic tick
);

    logic s1_reg;
    logic s2_reg;
    logic s3_reg;

    // Two-flop synchroniser followed by a history flop for edge detection.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= slow_clk;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    // A level held high only ever produces one tick, on its leading edge.
    assign tick = s2_reg & ~s3_reg;

endmodule

// File: rtl/serial_parity_checker.sv
// Receives DATA_WIDTH data bits plus one parity bit, LSB first, one bit per
// rising edge of the divided clock, and reports word, parity status and a
// saturating error count.
module serial_parity_checker
    import serial_parity_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  slow_clk,
    input  logic                  serial_in,
    input  logic                  start,
    input  logic                  clr_cnt,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_valid,
    output logic                  parity_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0]        LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_t                state_reg;
    state_t                state_next;
    logic                  tick;
    logic [DATA_WIDTH-1:0] shreg_reg;
    logic [BW-1:0]         bit_cnt_reg;
    logic                  acc_reg;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  frame_valid_reg;
    logic                  parity_err_reg;
    logic [CNT_WIDTH-1:0]  err_count_reg;
    logic                  mismatch;

    edge_tick_sync u_tick (
        .clk_in   (clk_in),
        .reset    (reset),
        .slow_clk (slow_clk),
        .tick     (tick)
    );

    // Accumulator already holds the seed xor all data bits; a correct parity
    // bit brings it back to zero.
    assign mismatch = acc_reg ^ serial_in;

    // FSM state register.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; ticks seen in IDLE (including one coinciding with
    // start) are not treated as data.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = DATA;
            DATA:    if (tick && (bit_cnt_reg == LAST_BIT)) state_next = PARITY;
            PARITY:  if (tick) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shift register, parity accumulator, result registers and error counter.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            shreg_reg       <= '0;
            bit_cnt_reg     <= '0;
            acc_reg         <= 1'b0;
            data_out_reg    <= '0;
            frame_valid_reg <= 1'b0;
            parity_err_reg  <= 1'b0;
            err_count_reg   <= '0;
        end else begin
            frame_valid_reg <= 1'b0;
            parity_err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        bit_cnt_reg <= '0;
                        acc_reg     <= parity_seed(ODD_PARITY);
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg_reg   <= {serial_in, shreg_reg[DATA_WIDTH-1:1]};
                        acc_reg     <= acc_reg ^ serial_in;
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                PARITY: begin
                    // Results are registered here so they are visible during DONE.
                    if (tick) begin
                        data_out_reg    <= shreg_reg;
                        frame_valid_reg <= 1'b1;
                        parity_err_reg  <= mismatch;
                        if (mismatch && (err_count_reg != CNT_MAX)) begin
                            err_count_reg <= err_count_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            // Clear takes priority over a simultaneous increment.
            if (clr_cnt) begin
                err_count_reg <= '0;
            end
        end
    end

    assign data_out    = data_out_reg;
    assign frame_valid = frame_valid_reg;
    assign parity_err  = parity_err_reg;
    assign busy        = (state_reg != IDLE);
    assign err_count   = err_count_reg;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: three instances (even parity, odd
// parity, 2-bit saturating counter) share the serial line and divided clock
// but each has its own start and clear.
module tb_serial_parity_checker;
    import serial_parity_checker_pkg::*;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic            reset;
    logic            slow_clk;
    logic            serial_in;
    logic [2:0]      start;
    logic [2:0]      clr_cnt;
    logic [2:0]      fv;
    logic [2:0]      pe;
    logic [2:0]      busy;
    logic [2:0][7:0] dout;
    logic [7:0]      cnt_e;
    logic [7:0]      cnt_o;
    logic [1:0]      cnt_s;

    int checks   = 0;
    int failures = 0;

    int         fv_count [3] = '{0, 0, 0};
    int         stray_pe [3] = '{0, 0, 0};
    logic [7:0] last_data[3] = '{8'h00, 8'h00, 8'h00};
    logic       last_pe  [3] = '{1'b0, 1'b0, 1'b0};

    serial_parity_checker #(.DATA_WIDTH(8), .ODD_PARITY(0), .CNT_WIDTH(8)) dut_even (
        .clk_in(clk_in), .reset(reset), .slow_clk(slow_clk), .serial_in(serial_in),
        .start(start[0]), .clr_cnt(clr_cnt[0]), .data_out(dout[0]),
        .frame_valid(fv[0]), .parity_err(pe[0]), .busy(busy[0]), .err_count(cnt_e)
    );

    serial_parity_checker #(.DATA_WIDTH(8), .ODD_PARITY(1), .CNT_WIDTH(8)) dut_odd (
        .clk_in(clk_in), .reset(reset), .slow_clk(slow_clk), .serial_in(serial_in),
        .start(start[1]), .clr_cnt(clr_cnt[1]), .data_out(dout[1]),
        .frame_valid(fv[1]), .parity_err(pe[1]), .busy(busy[1]), .err_count(cnt_o)
    );

    serial_parity_checker #(.DATA_WIDTH(8), .ODD_PARITY(0), .CNT_WIDTH(2)) dut_sat (
        .clk_in(clk_in), .reset(reset), .slow_clk(slow_clk), .serial_in(serial_in),
        .start(start[2]), .clr_cnt(clr_cnt[2]), .data_out(dout[2]),
        .frame_valid(fv[2]), .parity_err(pe[2]), .busy(busy[2]), .err_count(cnt_s)
    );

    // Record every frame_valid strobe, and any parity_err seen without one.
    always @(negedge clk_in) begin
        for (int i = 0; i < 3; i++) begin
            if (fv[i] === 1'b1) begin
                fv_count[i]++;
                last_data[i] = dout[i];
                last_pe[i]   = pe[i];
            end else if (pe[i] === 1'b1) begin
                stray_pe[i]++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One slow_clk period: bit presented with the rising edge, held while high.
    task automatic send_bit(input logic b, input int hi);
        @(posedge clk_in); #1;
        serial_in = b;
        slow_clk  = 1'b1;
        repeat (hi) @(posedge clk_in);
        #1 slow_clk = 1'b0;
        repeat (4) @(posedge clk_in);
    endtask

    task automatic pulse_start(input int d);
        @(posedge clk_in); #1 start[d] = 1'b1;
        @(posedge clk_in); #1 start[d] = 1'b0;
    endtask

    // Full frame to instance d. restart_at: re-pulse start before that data
    // bit; long_at: hold slow_clk high 50 cycles for that bit; clr_par: hold
    // clr_cnt high across the parity bit. lat = negedge index (counted from the
    // parity-bit rise) where frame_valid is first seen; width = strobe length.
    task automatic send_frame(input int d, input logic [7:0] data, input logic par,
                              input int restart_at, input int long_at, input logic clr_par,
                              output int lat, output int width);
        pulse_start(d);
        for (int i = 0; i < 8; i++) begin
            if (i == restart_at) begin
                start[d] = 1'b1;
                @(posedge clk_in); #1 start[d] = 1'b0;
            end
            send_bit(data[i], (i == long_at) ? 50 : 4);
        end
        @(posedge clk_in); #1;
        serial_in  = par;
        slow_clk   = 1'b1;
        clr_cnt[d] = clr_par;
        lat   = 0;
        width = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_in);
            if (fv[d] === 1'b1) begin
                width++;
                if (lat == 0) lat = k;
            end
        end
        @(posedge clk_in); #1;
        slow_clk   = 1'b0;
        clr_cnt[d] = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        $display("frame dut=%0d data=0x%02h par=%0b lat=%0d width=%0d", d, data, par, lat, width);
    endtask

    int lat;
    int width;

    initial begin
        reset     = 1'b1;
        slow_clk  = 1'b0;
        serial_in = 1'b0;
        start     = '0;
        clr_cnt   = '0;
        #2 reset  = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_dout",  dout[0], 0);
        check("rst_fv",    fv, 0);
        check("rst_pe",    pe, 0);
        check("rst_busy",  busy, 0);
        check("rst_cnt_e", cnt_e, 0);
        check("rst_cnt_s", cnt_s, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk_in);

        // Even parity, 0xA5 (four ones) with parity 0: clean frame. Strobe
        // appears on the 4th negedge: two sync stages, tick, then DONE.
        send_frame(0, 8'hA5, 1'b0, -1, -1, 1'b0, lat, width);
        check("good_lat",   lat, 4);
        check("good_width", width, 1);
        check("good_cnt",   fv_count[0], 1);
        check("good_data",  last_data[0], 8'hA5);
        check("good_pe",    last_pe[0], 0);
        check("good_errc",  cnt_e, 0);
        check("good_busy",  busy[0], 0);
        check("good_hold",  dout[0], 8'hA5);

        // Even parity, 0xA5 with parity 1: error flagged and counted.
        send_frame(0, 8'hA5, 1'b1, -1, -1, 1'b0, lat, width);
        check("bad_cnt",   fv_count[0], 2);
        check("bad_data",  last_data[0], 8'hA5);
        check("bad_pe",    last_pe[0], 1);
        check("bad_errc",  cnt_e, 1);

        // Odd parity, 0x00: parity 1 is correct, parity 0 is an error.
        send_frame(1, 8'h00, 1'b1, -1, -1, 1'b0, lat, width);
        check("odd_ok_pe",   last_pe[1], 0);
        check("odd_ok_errc", cnt_o, 0);
        check("odd_ok_data", last_data[1], 8'h00);
        send_frame(1, 8'h00, 1'b0, -1, -1, 1'b0, lat, width);
        check("odd_bad_pe",   last_pe[1], 1);
        check("odd_bad_errc", cnt_o, 1);
        check("odd_fv_cnt",   fv_count[1], 2);

        // Even, 0x5A: start re-pulsed before bit 3, bit 5 held high 50 cycles.
        send_frame(0, 8'h5A, 1'b0, 3, 5, 1'b0, lat, width);
        check("robust_cnt",   fv_count[0], 3);
        check("robust_data",  last_data[0], 8'h5A);
        check("robust_pe",    last_pe[0], 0);
        check("robust_width", width, 1);
        check("robust_errc",  cnt_e, 1);

        // Reset after three data bits: outputs clear at once, frame dropped.
        pulse_start(0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 4);
        @(posedge clk_in); #1;
        check("mid_busy", busy[0], 1);
        reset = 1'b0;
        #1;
        check("arst_dout",  dout[0], 0);
        check("arst_busy",  busy[0], 0);
        check("arst_cnt_e", cnt_e, 0);
        check("arst_cnt_o", cnt_o, 0);
        check("arst_fv",    fv[0], 0);
        repeat (2) @(posedge clk_in);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        check("arst_nofv", fv_count[0], 3);
        send_frame(0, 8'h3C, 1'b0, -1, -1, 1'b0, lat, width);
        check("post_cnt",  fv_count[0], 4);
        check("post_data", last_data[0], 8'h3C);
        check("post_pe",   last_pe[0], 0);

        // 2-bit counter: five bad frames saturate at 3.
        for (int n = 1; n <= 5; n++) begin
            send_frame(2, 8'hA5, 1'b1, -1, -1, 1'b0, lat, width);
            check("sat_errc", cnt_s, (n < 3) ? n : 3);
        end
        // Clear held across the increment and DONE cycle wins.
        send_frame(2, 8'hA5, 1'b1, -1, -1, 1'b1, lat, width);
        check("clr_pe",   last_pe[2], 1);
        check("clr_errc", cnt_s, 0);
        send_frame(2, 8'hA5, 1'b1, -1, -1, 1'b0, lat, width);
        check("resume_errc", cnt_s, 1);
        check("sat_fv_cnt",  fv_count[2], 7);

        check("stray_pe0", stray_pe[0], 0);
        check("stray_pe1", stray_pe[1], 0);
        check("stray_pe2", stray_pe[2], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
